spi_pc_receiver: RTL and testbench

- SPI mode-0 target that receives the frames driven on spi_sck/pc_cs/pc_mosi by the soc and presents each completed word on a valid/ready stream.
- Used in the soc bench as a self-checking monitor, and in the FPGA top as a loopback target.
- Oversampled design: all SPI pins are synchronised into the clk domain; no logic is clocked by spi_sck.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_pin_sync.sv | 36 +++
 rtl/spi_pc_receiver.sv | 178 +++++++++++++++++
 tb/tb_spi_pc_receiver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the oversampled SPI receiver.
package spi_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam logic [31:0] FIB_A = 32'h6D73E55F;
  localparam logic [31:0] FIB_B = 32'hB11924E1;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchroniser for one SPI pin, with a previous-value register for edge detection.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] stages_q, stages_d;
  logic                   prev_q, prev_d;

  always_comb begin
    stages_d = {stages_q[SYNC_STAGES-2:0], pin_i};
    prev_d   = stages_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stages_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q   <= RESET_VAL;
    end else begin
      stages_q <= stages_d;
      prev_q   <= prev_d;
    end
  end

  assign sync_o = stages_q[SYNC_STAGES-1];
  assign rise_o = stages_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~stages_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_pc_receiver.sv
// SPI mode-0 target, oversampled in the clk domain, delivering words on a valid/ready stream.
// Define SPI_RX_MISO_EN to add spi_miso, which echoes the previously received word.
module spi_pc_receiver
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              pc_cs,
  input  logic              pc_mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err
`ifdef SPI_RX_MISO_EN
  ,
  output logic              spi_miso
`endif
);

  localparam int unsigned     CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  logic sck_rise, sck_fall, cs_r, mosi_r;
  logic unused_sck_r, unused_cs_rise, unused_cs_fall, unused_mosi_rise, unused_mosi_fall;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sync_sck (
    .clk_i (clk),
    .rst_ni(rst_n),
    .pin_i (spi_sck),
    .sync_o(unused_sck_r),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_sync_cs (
    .clk_i (clk),
    .rst_ni(rst_n),
    .pin_i (pc_cs),
    .sync_o(cs_r),
    .rise_o(unused_cs_rise),
    .fall_o(unused_cs_fall)
  );

  // Same depth as sck so each sampled bit lines up with its detected rise.
  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sync_mosi (
    .clk_i (clk),
    .rst_ni(rst_n),
    .pin_i (pc_mosi),
    .sync_o(mosi_r),
    .rise_o(unused_mosi_rise),
    .fall_o(unused_mosi_fall)
  );

  spi_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;
  logic [DATA_W-1:0] word;
  logic              complete;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    complete    = 1'b0;
    word        = {shift_q[DATA_W-2:0], mosi_r};

    unique case (state_q)
      IDLE: begin
        if (!cs_r) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cs_r) begin
          state_d     = IDLE;
          frame_err_d = (cnt_q != '0);
          cnt_d       = '0;
        end else if (sck_rise) begin
          shift_d = word;
          if (cnt_q == CntLast) begin
            complete = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A handshake in the completing clk frees the holding register for the new word.
    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = word;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

`ifdef SPI_RX_MISO_EN
  logic [DATA_W-1:0] tx_q, tx_d;

  always_comb begin
    tx_d = tx_q;
    if (state_q == IDLE && !cs_r) begin
      tx_d = rx_data_q;
    end else if (state_q == SHIFT && sck_fall) begin
      tx_d = {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q <= '0;
    end else begin
      tx_q <= tx_d;
    end
  end

  assign spi_miso = !cs_r && tx_q[DATA_W-1];
`else
  logic unused_sck_fall;
  assign unused_sck_fall = sck_fall;
`endif

endmodule

// File: tb/tb_spi_pc_receiver.sv
// Self-checking bench for spi_pc_receiver: frame table plus reset, back-to-back,
// backpressure and optional MISO echo sequences; received words checked against a queue.
module tb_spi_pc_receiver;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, spi_sck, pc_cs, pc_mosi, rx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, overrun, frame_err;
`ifdef SPI_RX_MISO_EN
  logic        spi_miso;
`endif

  always #5 clk = ~clk;

  spi_pc_receiver #(
    .DATA_W     (32),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi_sck  (spi_sck),
    .pc_cs    (pc_cs),
    .pc_mosi  (pc_mosi),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .overrun  (overrun),
    .frame_err(frame_err)
`ifdef SPI_RX_MISO_EN
    ,
    .spi_miso (spi_miso)
`endif
  );

  int          tests    = 0;
  int          failures = 0;
  int          err_cycles = 0;
  logic [31:0] exp_q[$];
  logic [31:0] miso_cap;

  typedef struct {
    logic [31:0] data;
    int          bits;
    logic        exp_word;
    int          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Half-period of 4 clk; the initiator samples miso just before each rise.
  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      pc_mosi = w[31-i];
      wait_clk(4);
`ifdef SPI_RX_MISO_EN
      miso_cap = {miso_cap[30:0], spi_miso};
`endif
      spi_sck = 1'b1;
      wait_clk(4);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input int n);
    pc_cs = 1'b0;
    wait_clk(6);
    shift_bits(w, n);
    wait_clk(4);
    pc_cs = 1'b1;
    wait_clk(8);
  endtask

  // Scoreboard: a word is consumed at the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        failures++;
        $display("FAIL unexpected_word: got %h expected none", rx_data);
      end else begin
        check("rx_word", rx_data, exp_q.pop_front());
      end
    end
    if (frame_err) err_cycles++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[8];
    int   e0;

    tbl[0] = '{FIB_A,        32, 1'b1, 0};
    tbl[1] = '{FIB_A,        13, 1'b0, 1};
    tbl[2] = '{FIB_B,        32, 1'b1, 0};
    tbl[3] = '{32'h00000000, 32, 1'b1, 0};
    tbl[4] = '{32'hFFFFFFFF, 32, 1'b1, 0};
    tbl[5] = '{32'h80000001,  0, 1'b0, 0};
    tbl[6] = '{32'h80000001, 31, 1'b0, 1};
    tbl[7] = '{32'h80000001, 32, 1'b1, 0};

    rst_n    = 1'b0;
    spi_sck  = 1'b0;
    pc_cs    = 1'b1;
    pc_mosi  = 1'b0;
    rx_ready = 1'b1;
    miso_cap = '0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      spi_sck = ~spi_sck;
      pc_cs   = ~pc_cs;
      pc_mosi = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset_rx_data", rx_data, 32'h0);
      check("reset_flags", {29'b0, rx_valid, overrun, frame_err}, 32'h0);
    end
    spi_sck = 1'b0;
    pc_cs   = 1'b1;
    pc_mosi = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(5);

    for (int i = 0; i < 8; i++) begin
      e0 = err_cycles;
      if (tbl[i].exp_word) exp_q.push_back(tbl[i].data);
      send_frame(tbl[i].data, tbl[i].bits);
      wait_clk(6);
      check("frame_err_cycles", 32'(err_cycles - e0), 32'(tbl[i].exp_err));
      check("words_drained", 32'(exp_q.size()), 32'h0);
    end

    // Back-to-back frames under a single cs assertion.
    exp_q.push_back(FIB_A);
    exp_q.push_back(FIB_B);
    pc_cs = 1'b0;
    wait_clk(6);
    shift_bits(FIB_A, 32);
    shift_bits(FIB_B, 32);
    wait_clk(4);
    pc_cs = 1'b1;
    wait_clk(8);
    check("b2b_drained", 32'(exp_q.size()), 32'h0);
    check("b2b_overrun", {31'b0, overrun}, 32'h0);

    // Reset mid-frame: the partial FIB_B must vanish without a frame_err.
    e0 = err_cycles;
    exp_q.push_back(FIB_A);
    pc_cs = 1'b0;
    wait_clk(6);
    shift_bits(FIB_B, 16);
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(2);
    pc_cs = 1'b1;
    wait_clk(8);
    send_frame(FIB_A, 32);
    wait_clk(6);
    check("rst_mid_frame_err", 32'(err_cycles - e0), 32'h0);
    check("rst_mid_drained", 32'(exp_q.size()), 32'h0);

`ifdef SPI_RX_MISO_EN
    exp_q.push_back(FIB_A);
    send_frame(FIB_A, 32);
    exp_q.push_back(32'h0);
    miso_cap = '0;
    send_frame(32'h0, 32);
    wait_clk(6);
    check("miso_echo", miso_cap, FIB_A);
`endif

    // Backpressure: second frame overruns, first word is held.
    rx_ready = 1'b0;
    send_frame(FIB_A, 32);
    wait_clk(4);
    check("bp_valid_1", {31'b0, rx_valid}, 32'h1);
    check("bp_data_1", rx_data, FIB_A);
    check("bp_overrun_1", {31'b0, overrun}, 32'h0);
    send_frame(FIB_B, 32);
    wait_clk(4);
    check("bp_valid_2", {31'b0, rx_valid}, 32'h1);
    check("bp_data_2", rx_data, FIB_A);
    check("bp_overrun_2", {31'b0, overrun}, 32'h1);
    exp_q.push_back(FIB_A);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", {31'b0, rx_valid}, 32'h0);
    check("bp_data_hold", rx_data, FIB_A);
    check("bp_overrun_sticky", {31'b0, overrun}, 32'h1);
    wait_clk(4);
    check("bp_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
